// File: rtl/program_loader.sv
// program_loader: UART bootloader for the 16-byte RAM of the 8-bit computer.
// It receives a frame on rx (header byte, MEM_DEPTH image bytes, then a
// checksum byte), writes the image through the program-mode RAM port and
// reports whether the load passed or failed.
//
// Ports:
//   fastClk   system clock
//   rst       asynchronous, active-high reset
//   rx        UART serial input: idle high, 8N1, LSB first, asynchronous
//   prog_mode high while an image is being written
//   addr      RAM write address
//   data      RAM write data
//   we        one-cycle write strobe; addr/data are valid while it is high
//   busy      copy of prog_mode
//   load_ok   one-cycle pulse when the image loaded and the checksum matched
//   load_err  sticky error flag, cleared when the next header is accepted
module program_loader #(
    parameter int unsigned CLKS_PER_BIT = 16,
    parameter logic [7:0]  HDR_BYTE     = 8'hA5,
    parameter int unsigned MEM_DEPTH    = 16
) (
    input  logic       fastClk,
    input  logic       rst,
    input  logic       rx,
    output logic       prog_mode,
    output logic [3:0] addr,
    output logic [7:0] data,
    output logic       we,
    output logic       busy,
    output logic       load_ok,
    output logic       load_err
);

    localparam int unsigned ADDR_W = 4;
    localparam int unsigned CNT_W  = $clog2(CLKS_PER_BIT);
    localparam logic [CNT_W-1:0]  HALF_M1 = CNT_W'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CNT_W-1:0]  FULL_M1 = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [ADDR_W-1:0] LAST    = ADDR_W'(MEM_DEPTH - 1);

    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;
    typedef enum logic [1:0] {WAIT_HDR, LOAD, CHECK} ld_state_t;

    // ---------------- UART receiver ----------------
    logic             rx_meta, rx_sync, rx_prev;
    rx_state_t        rx_state, rx_state_n;
    logic [CNT_W-1:0] bit_cnt, bit_cnt_n;
    logic [2:0]       bit_idx, bit_idx_n;
    logic [7:0]       shreg, shreg_n;
    logic             byte_valid, byte_valid_n;
    logic             frame_err, frame_err_n;

    // Two-flop synchronizer plus a delayed copy for falling-edge detection.
    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            rx_meta <= 1'b1;
            rx_sync <= 1'b1;
            rx_prev <= 1'b1;
        end else begin
            rx_meta <= rx;
            rx_sync <= rx_meta;
            rx_prev <= rx_sync;
        end
    end

    // Receiver state register.
    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            rx_state   <= RX_IDLE;
            bit_cnt    <= '0;
            bit_idx    <= '0;
            shreg      <= '0;
            byte_valid <= 1'b0;
            frame_err  <= 1'b0;
        end else begin
            rx_state   <= rx_state_n;
            bit_cnt    <= bit_cnt_n;
            bit_idx    <= bit_idx_n;
            shreg      <= shreg_n;
            byte_valid <= byte_valid_n;
            frame_err  <= frame_err_n;
        end
    end

    // Receiver next state: mid-bit sampling from the detected start edge.
    always_comb begin
        rx_state_n   = rx_state;
        bit_cnt_n    = bit_cnt + CNT_W'(1);
        bit_idx_n    = bit_idx;
        shreg_n      = shreg;
        byte_valid_n = 1'b0;
        frame_err_n  = 1'b0;
        case (rx_state)
            RX_IDLE: begin
                bit_cnt_n = '0;
                if (rx_prev && !rx_sync) rx_state_n = RX_START;
            end
            RX_START: begin
                if (bit_cnt == HALF_M1) begin
                    bit_cnt_n  = '0;
                    bit_idx_n  = '0;
                    // A start bit that is gone by mid-bit was a glitch.
                    rx_state_n = rx_sync ? RX_IDLE : RX_DATA;
                end
            end
            RX_DATA: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_n = '0;
                    shreg_n   = {rx_sync, shreg[7:1]};
                    bit_idx_n = bit_idx + 3'd1;
                    if (bit_idx == 3'd7) rx_state_n = RX_STOP;
                end
            end
            RX_STOP: begin
                if (bit_cnt == FULL_M1) begin
                    bit_cnt_n    = '0;
                    byte_valid_n = rx_sync;
                    frame_err_n  = !rx_sync;
                    // Leave at mid stop bit so a back-to-back start edge is seen.
                    rx_state_n   = RX_IDLE;
                end
            end
            default: rx_state_n = RX_IDLE;
        endcase
    end

    // ---------------- Loader ----------------
    ld_state_t         ld_state, ld_state_n;
    logic [ADDR_W-1:0] count, count_n;
    logic [7:0]        sum, sum_n;
    logic              prog_mode_n;
    logic [ADDR_W-1:0] addr_n;
    logic [7:0]        data_n;
    logic              we_n, load_ok_n, load_err_n;

    // Loader state and output registers.
    always_ff @(posedge fastClk or posedge rst) begin
        if (rst) begin
            ld_state  <= WAIT_HDR;
            count     <= '0;
            sum       <= '0;
            prog_mode <= 1'b0;
            addr      <= '0;
            data      <= '0;
            we        <= 1'b0;
            load_ok   <= 1'b0;
            load_err  <= 1'b0;
        end else begin
            ld_state  <= ld_state_n;
            count     <= count_n;
            sum       <= sum_n;
            prog_mode <= prog_mode_n;
            addr      <= addr_n;
            data      <= data_n;
            we        <= we_n;
            load_ok   <= load_ok_n;
            load_err  <= load_err_n;
        end
    end

    // Loader next state: header hunt, image write, checksum compare.
    always_comb begin
        ld_state_n  = ld_state;
        count_n     = count;
        sum_n       = sum;
        prog_mode_n = prog_mode;
        addr_n      = addr;
        data_n      = data;
        we_n        = 1'b0;
        load_ok_n   = 1'b0;
        load_err_n  = load_err;
        case (ld_state)
            WAIT_HDR: begin
                if (byte_valid && shreg == HDR_BYTE) begin
                    ld_state_n  = LOAD;
                    prog_mode_n = 1'b1;
                    load_err_n  = 1'b0;
                    sum_n       = '0;
                    count_n     = '0;
                end
            end
            LOAD: begin
                if (frame_err) begin
                    load_err_n  = 1'b1;
                    prog_mode_n = 1'b0;
                    ld_state_n  = WAIT_HDR;
                end else if (byte_valid) begin
                    // Header values here are ordinary image data.
                    data_n  = shreg;
                    addr_n  = count;
                    sum_n   = sum + shreg;
                    count_n = count + ADDR_W'(1);
                    we_n    = 1'b1;
                    if (count == LAST) ld_state_n = CHECK;
                end
            end
            CHECK: begin
                if (frame_err) begin
                    load_err_n  = 1'b1;
                    prog_mode_n = 1'b0;
                    ld_state_n  = WAIT_HDR;
                end else if (byte_valid) begin
                    if (shreg == sum) load_ok_n = 1'b1;
                    else              load_err_n = 1'b1;
                    prog_mode_n = 1'b0;
                    ld_state_n  = WAIT_HDR;
                end
            end
            default: ld_state_n = WAIT_HDR;
        endcase
    end

    assign busy = prog_mode;

endmodule
